// File: rtl/i2c_slave_pkg.sv
// i2c_slave_pkg: shared FSM state type, bus-level constants and the majority
// helper used by the optional SCL/SDA glitch filter.
package i2c_slave_pkg;
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_DATA     = 3'd3,
      ST_DATA_ACK = 3'd4,
      ST_IGNORE   = 3'd5
   } i2c_rx_state_t;
   localparam logic I2C_ACK           = 1'b0;
   localparam logic I2C_NACK          = 1'b1;
   localparam int   I2C_BITS_PER_BYTE = 8;
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction
endpackage

// File: rtl/i2c_slave_rx_fifo.sv
// i2c_slave_rx_fifo: 8-bit first-word-fall-through RX buffer; a pop frees room
// for a push in the same cycle even when full.
module i2c_slave_rx_fifo
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic [7:0]                   din_i,
   output logic [7:0]                   dout_o,
   output logic [$clog2(FIFO_DEPTH):0]  count_o
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] count_q;
   logic          full, empty, do_push, do_pop;
   assign empty   = count_q == '0;
   assign full    = count_q == CW'(FIFO_DEPTH);
   assign do_pop  = pop_i & ~empty;
   assign do_push = push_i & (~full | do_pop);
   assign dout_o  = empty ? 8'h00 : mem_q[rd_q];
   assign count_o = count_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= do_push ? wr_q + 1'b1 : wr_q;
         rd_q    <= do_pop ? rd_q + 1'b1 : rd_q;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end
endmodule

// File: rtl/i2c_slave_rx_ctrl.sv
// i2c_slave_rx_ctrl: I2C slave write receiver - sync, START/STOP detect, address match,
// ACK drive and RX FIFO. Define I2C_SLAVE_GLITCH_FILTER_EN for a 3-sample SCL/SDA filter.
module i2c_slave_rx_ctrl
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = 7'h42,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_pop,
   output logic       overrun,
   input  logic       ovr_clr,
   output logic       busy
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   logic [1:0]    scl_sync_q, sda_sync_q;
   logic          scl_f, sda_f, scl_q, sda_q, scl_prev_q, sda_prev_q;
   logic          scl_rise, scl_fall, start, stop;
   i2c_rx_state_t state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [6:0]    shift_q, shift_d;
   logic [7:0]    byte_w;
   logic          lvl_q, lvl_d, busy_q, busy_d, ovr_q, push, ovr_set, can_push;
   logic [CW-1:0] count;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q, sda_hist_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      end
   end
   assign scl_f = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
   assign sda_f = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
`else
   assign scl_f = scl_sync_q[1];
   assign sda_f = sda_sync_q[1];
`endif
   assign scl_rise = scl_q & ~scl_prev_q;
   assign scl_fall = ~scl_q & scl_prev_q;
   assign start    = scl_q & scl_prev_q & sda_prev_q & ~sda_q;
   assign stop     = scl_q & scl_prev_q & ~sda_prev_q & sda_q;
   assign byte_w   = {shift_q, sda_q};
   assign can_push = count != CW'(FIFO_DEPTH) || rx_pop;
   assign sda_oe   = lvl_q == I2C_ACK;
   assign rx_valid = count != '0;
   assign busy     = busy_q;
   assign overrun  = ovr_q;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      lvl_d   = lvl_q;
      busy_d  = busy_q;
      push    = 1'b0;
      ovr_set = 1'b0;
      if (start || stop) begin
         state_d = start ? ST_ADDR : ST_IDLE;
         cnt_d   = '0;
         lvl_d   = I2C_NACK;
         busy_d  = 1'b0;
      end else if ((state_q == ST_ADDR || state_q == ST_DATA) && scl_rise) begin
         shift_d = byte_w[6:0];
         cnt_d   = cnt_q + 3'd1;
         if (cnt_q == 3'(I2C_BITS_PER_BYTE - 1)) begin
            if (state_q == ST_ADDR) begin
               busy_d  = byte_w[7:1] == SLAVE_ADDR && !byte_w[0];
               state_d = busy_d ? ST_ADDR_ACK : ST_IGNORE;
            end else begin
               push    = can_push;
               ovr_set = !can_push;
               state_d = can_push ? ST_DATA_ACK : ST_IGNORE;
            end
         end
      end else if ((state_q == ST_ADDR_ACK || state_q == ST_DATA_ACK) && scl_fall) begin
         // first fall starts driving ACK, second fall releases it
         lvl_d   = sda_oe ? I2C_NACK : I2C_ACK;
         state_d = sda_oe ? ST_DATA : state_q;
         cnt_d   = '0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
         scl_q      <= 1'b1;
         sda_q      <= 1'b1;
         scl_prev_q <= 1'b1;
         sda_prev_q <= 1'b1;
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         lvl_q      <= I2C_NACK;
         busy_q     <= 1'b0;
         ovr_q      <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], scl_in};
         sda_sync_q <= {sda_sync_q[0], sda_in};
         scl_q      <= scl_f;
         sda_q      <= sda_f;
         scl_prev_q <= scl_q;
         sda_prev_q <= sda_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         lvl_q      <= lvl_d;
         busy_q     <= busy_d;
         ovr_q      <= ovr_set | (ovr_q & ~ovr_clr);
      end
   end
   i2c_slave_rx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .pop_i   (rx_pop),
      .din_i   (byte_w),
      .dout_o  (rx_data),
      .count_o (count)
   );
endmodule
